// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// alu_ctrl_pkg : shared widths, op/state encodings and result-capture helper
// Revision     : 1.0
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  localparam int DW = 4;
  localparam int RW = 5;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 2;

  // Encoding doubles as {select1, select0} towards the ALU.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Bit 4 of the diff/and buses is not driven by the datapath, so it is masked.
  function automatic logic [RW-1:0] capture_result(input op_e           op,
                                                   input logic [RW-1:0] sum,
                                                   input logic [RW-1:0] diff,
                                                   input logic [RW-1:0] andv);
    logic [RW-1:0] res;
    res = '0;
    case (op)
      OP_ADD:  res = sum;
      OP_SUB:  res = {1'b0, diff[DW-1:0]};
      OP_AND:  res = {1'b0, andv[DW-1:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2  : two-way arbiter, round-robin on ptr_i or fixed priority to req0
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = (PRIO_FIXED || !ptr_i) ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_req_sched.sv
// ============================================================================
// alu_req_sched : shares one 4-bit ALU between two requesters, returns results
//                 on a valid/ready channel. ALU_STATS_EN adds handshake counters.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module alu_req_sched
  import alu_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit PRIO_FIXED    = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [1:0]    req0_op_i,
  input  logic [DW-1:0] req0_a_i,
  input  logic [DW-1:0] req0_b_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [1:0]    req1_op_i,
  input  logic [DW-1:0] req1_a_i,
  input  logic [DW-1:0] req1_b_i,
  output logic          alu_select0_o,
  output logic          alu_select1_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  input  logic [RW-1:0] alu_sum_i,
  input  logic [RW-1:0] alu_diff_i,
  input  logic [RW-1:0] alu_and_i,
  input  logic          alu_eq_i,
  input  logic          alu_gt_i,
  input  logic          alu_lt_i,
`ifdef ALU_STATS_EN
  output logic [15:0]   stat_cnt0_o,
  output logic [15:0]   stat_cnt1_o,
`endif
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic          resp_id_o,
  output logic [RW-1:0] resp_result_o,
  output logic [2:0]    resp_flags_o
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  op_e           op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          id_q, id_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RW-1:0] res_q, res_d;
  logic [2:0]    flags_q, flags_d;
  logic [1:0]    w_grant;

  rr_arb2 #(
    .PRIO_FIXED (PRIO_FIXED)
  ) u_arb (
    .valid_i (({req1_valid_i, req0_valid_i})),
    .ptr_i   (ptr_q),
    .grant_o (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    flags_d       = flags_q;
    req0_ready_o  = 1'b0;
    req1_ready_o  = 1'b0;
    alu_select0_o = 1'b0;
    alu_select1_o = 1'b0;
    alu_a_o       = '0;
    alu_b_o       = '0;
    resp_valid_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req0_ready_o = w_grant[0];
        req1_ready_o = w_grant[1];
        if (|w_grant) begin
          id_d    = w_grant[1];
          op_d    = w_grant[1] ? op_e'(req1_op_i) : op_e'(req0_op_i);
          a_d     = w_grant[1] ? req1_a_i : req0_a_i;
          b_d     = w_grant[1] ? req1_b_i : req0_b_i;
          // Pointer always hands priority to the requester that just lost out.
          ptr_d   = ~w_grant[1];
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_select0_o = op_q[0];
        alu_select1_o = op_q[1];
        alu_a_o       = a_q;
        alu_b_o       = b_q;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          res_d   = capture_result(op_q, alu_sum_i, alu_diff_i, alu_and_i);
          flags_d = (op_q == OP_CMP) ? {alu_lt_i, alu_gt_i, alu_eq_i} : 3'b000;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_id_o     = id_q;
  assign resp_result_o = res_q;
  assign resp_flags_o  = flags_q;

`ifdef ALU_STATS_EN
  logic        w_hs;
  logic [15:0] stat_cnt0_q, stat_cnt1_q;

  assign w_hs = resp_valid_o & resp_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else if (w_hs) begin
      if (!id_q && stat_cnt0_q != 16'hFFFF) stat_cnt0_q <= stat_cnt0_q + 16'd1;
      if (id_q && stat_cnt1_q != 16'hFFFF)  stat_cnt1_q <= stat_cnt1_q + 16'd1;
    end
  end

  assign stat_cnt0_o = stat_cnt0_q;
  assign stat_cnt1_o = stat_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_req_sched.sv
// ============================================================================
// tb_alu_req_sched : self-checking bench for alu_req_sched (round-robin and
//                    fixed-priority instances) against a transaction-level model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_alu_req_sched;

  localparam int SETTLE   = 1;
  localparam int F_SETTLE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1, r0, r1;
  logic [1:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       s0, s1;
  logic [3:0] aa, ab;
  logic [4:0] sum, diff, andr;
  logic       eq, gt, lt;
  logic       rv, rr, rid;
  logic [4:0] rres;
  logic [2:0] rfl;

  logic       f_v0, f_v1, f_r0, f_r1, f_s0, f_s1, f_rv, f_rid;
  logic       f_rr = 1'b1;
  logic [3:0] f_aa, f_ab;
  logic [4:0] f_sum, f_diff, f_and, f_res;
  logic       f_eq, f_gt, f_lt;
  logic [2:0] f_fl;

`ifdef ALU_STATS_EN
  logic [15:0] stat0, stat1, f_stat0, f_stat1;
`endif

  // Behavioural ALU: each result bus only live when its select code is driven;
  // the undriven bit4 of diff/and is modelled as 1 so the scheduler must mask it.
  assign sum  = ({s1, s0} == 2'b00) ? {1'b0, aa} + {1'b0, ab} : 5'd0;
  assign diff = ({s1, s0} == 2'b01) ? {1'b1, aa - ab} : 5'd0;
  assign andr = ({s1, s0} == 2'b11) ? {1'b1, aa & ab} : 5'd0;
  assign eq   = ({s1, s0} == 2'b10) && (aa == ab);
  assign gt   = ({s1, s0} == 2'b10) && (aa > ab);
  assign lt   = ({s1, s0} == 2'b10) && (aa < ab);

  assign f_sum  = ({f_s1, f_s0} == 2'b00) ? {1'b0, f_aa} + {1'b0, f_ab} : 5'd0;
  assign f_diff = ({f_s1, f_s0} == 2'b01) ? {1'b1, f_aa - f_ab} : 5'd0;
  assign f_and  = ({f_s1, f_s0} == 2'b11) ? {1'b1, f_aa & f_ab} : 5'd0;
  assign f_eq   = ({f_s1, f_s0} == 2'b10) && (f_aa == f_ab);
  assign f_gt   = ({f_s1, f_s0} == 2'b10) && (f_aa > f_ab);
  assign f_lt   = ({f_s1, f_s0} == 2'b10) && (f_aa < f_ab);

  alu_req_sched #(.SETTLE_CYCLES(SETTLE), .PRIO_FIXED(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
    .alu_select0_o(s0), .alu_select1_o(s1), .alu_a_o(aa), .alu_b_o(ab),
    .alu_sum_i(sum), .alu_diff_i(diff), .alu_and_i(andr),
    .alu_eq_i(eq), .alu_gt_i(gt), .alu_lt_i(lt),
`ifdef ALU_STATS_EN
    .stat_cnt0_o(stat0), .stat_cnt1_o(stat1),
`endif
    .resp_valid_o(rv), .resp_ready_i(rr), .resp_id_o(rid),
    .resp_result_o(rres), .resp_flags_o(rfl)
  );

  alu_req_sched #(.SETTLE_CYCLES(F_SETTLE), .PRIO_FIXED(1'b1)) u_dut_fix (
    .clk(clk), .rst(rst),
    .req0_valid_i(f_v0), .req0_ready_o(f_r0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(f_v1), .req1_ready_o(f_r1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
    .alu_select0_o(f_s0), .alu_select1_o(f_s1), .alu_a_o(f_aa), .alu_b_o(f_ab),
    .alu_sum_i(f_sum), .alu_diff_i(f_diff), .alu_and_i(f_and),
    .alu_eq_i(f_eq), .alu_gt_i(f_gt), .alu_lt_i(f_lt),
`ifdef ALU_STATS_EN
    .stat_cnt0_o(f_stat0), .stat_cnt1_o(f_stat1),
`endif
    .resp_valid_o(f_rv), .resp_ready_i(f_rr), .resp_id_o(f_rid),
    .resp_result_o(f_res), .resp_flags_o(f_fl)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference result: returns {flags[2:0], result[4:0]} from plain arithmetic.
  function automatic logic [7:0] ref_resp(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    int ia, ib, res, fl;
    ia = int'(a); ib = int'(b); res = 0; fl = 0;
    case (op)
      2'b00:   res = ia + ib;
      2'b01:   res = (ia - ib + 16) % 16;
      2'b10:   fl  = (ia < ib) ? 4 : ((ia > ib) ? 2 : 1);
      default: res = ia & ib;
    endcase
    return {fl[2:0], res[4:0]};
  endfunction

  // Main-instance model state
  int         m_busy, m_ptr, m_cnt, e_id;
  logic [1:0] e_op;
  logic [3:0] e_a, e_b;
  logic [4:0] e_res;
  logic [2:0] e_fl;
  bit         acc0, acc1, hold;
  int         grants[$];
  int         n_hs0, n_hs1, tot_hs;
  logic [4:0] last_res;
  logic [2:0] last_fl;
  logic       last_id;

  // Fixed-priority instance model state
  int         f_busy, f_cnt, f_eid;
  logic [4:0] f_eres;
  int         f_grants[$];

  task automatic model_step();
    int win;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_cnt = 0; n_hs0 = 0; n_hs1 = 0;
      return;
    end
    if (m_busy == 0) begin
      win = -1;
      if (v0 && v1)  win = m_ptr;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
      chk_eq("idle_rdy0", r0, win == 0);
      chk_eq("idle_rdy1", r1, win == 1);
      chk_eq("idle_resp_valid", rv, 0);
      chk_eq("idle_alu", {s1, s0, aa, ab}, 0);
      if (win >= 0) begin
        m_busy = 1; m_cnt = 0; m_ptr = 1 - win; e_id = win;
        e_op = win ? op1 : op0;
        e_a  = win ? a1 : a0;
        e_b  = win ? b1 : b0;
        {e_fl, e_res} = ref_resp(e_op, e_a, e_b);
        grants.push_back(win);
        if (win == 0) acc0 = 1'b1; else acc1 = 1'b1;
      end
    end else begin
      m_cnt++;
      chk_eq("busy_rdy", {r1, r0}, 0);
      if (m_cnt <= SETTLE) begin
        chk_eq("issue_resp_valid", rv, 0);
        chk_eq("issue_alu", {s1, s0, aa, ab}, {e_op, e_a, e_b});
      end else begin
        chk_eq("resp_valid", rv, 1);
        chk_eq("resp_alu", {s1, s0, aa, ab}, 0);
        chk_eq("resp_id", rid, e_id);
        chk_eq("resp_result", rres, e_res);
        chk_eq("resp_flags", rfl, e_fl);
        if (rr) begin
          m_busy = 0;
          tot_hs++;
          if (e_id == 0) n_hs0++; else n_hs1++;
          last_res = rres; last_fl = rfl; last_id = rid;
        end
      end
    end
  endtask

  task automatic fix_step();
    int win;
    if (rst) begin
      f_busy = 0; f_cnt = 0;
      return;
    end
    if (f_busy == 0) begin
      win = f_v0 ? 0 : (f_v1 ? 1 : -1);
      chk_eq("fix_rdy0", f_r0, win == 0);
      chk_eq("fix_rdy1", f_r1, win == 1);
      if (win >= 0) begin
        f_busy = 1; f_cnt = 0; f_eid = win;
        f_eres = win ? ref_resp(op1, a1, b1) : ref_resp(op0, a0, b0);
        f_grants.push_back(win);
      end
    end else begin
      f_cnt++;
      if (f_cnt <= F_SETTLE) begin
        chk_eq("fix_issue_resp_valid", f_rv, 0);
      end else begin
        chk_eq("fix_resp_valid", f_rv, 1);
        chk_eq("fix_resp", {f_rid, f_fl, f_res}, {f_eid[0], 8'(f_eres)});
        f_busy = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    fix_step();
    @(posedge clk);
    #1;
    if (acc0 && !hold) v0 = 1'b0;
    if (acc1 && !hold) v1 = 1'b0;
  endtask

  task automatic send(input int id, input logic [1:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic rdy);
    int k;
    if (id == 0) begin op0 = op; a0 = a; b0 = b; v0 = 1'b1; end
    else         begin op1 = op; a1 = a; b1 = b; v1 = 1'b1; end
    rr = rdy;
    k = 0;
    while (((id == 0) ? v0 : v1) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk_eq("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_busy != 0 || f_busy != 0 || v0 || v1) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) chk_eq("drain_timeout", 0, 1);
  endtask

  initial begin
    int k, hs_before;
    rst = 1'b1; hold = 1'b0; rr = 1'b0;
    v0 = 1'b0; v1 = 1'b0; f_v0 = 1'b0; f_v1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00; a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
    tot_hs = 0; f_busy = 0; m_busy = 0;
    repeat (3) tick();
    rst = 1'b0;

    chk_eq("reset_ready", {r1, r0, f_r1, f_r0}, 0);
    chk_eq("reset_resp", {rv, rid, rfl, rres}, 0);
    chk_eq("reset_alu", {s1, s0, aa, ab}, 0);
`ifdef ALU_STATS_EN
    chk_eq("reset_stats", {stat1, stat0}, 0);
`endif

    // Both requesters held valid from the first cycle out of reset
    op0 = 2'b00; a0 = 4'd1; b0 = 4'd2;
    op1 = 2'b01; a1 = 4'd7; b1 = 4'd3;
    v0 = 1'b1; v1 = 1'b1; f_v0 = 1'b1; f_v1 = 1'b1; rr = 1'b1; hold = 1'b1;
    k = 0;
    while ((grants.size() < 4 || f_grants.size() < 3) && k < 60) begin
      tick();
      k++;
    end
    hold = 1'b0; v0 = 1'b0; v1 = 1'b0; f_v0 = 1'b0; f_v1 = 1'b0;
    if (k >= 60) chk_eq("grant_timeout", 0, 1);
    else begin
      chk_eq("rr_grant_seq", {grants[0][0], grants[1][0], grants[2][0], grants[3][0]}, 4'b0101);
      chk_eq("fixed_grant_seq", {f_grants[0][0], f_grants[1][0], f_grants[2][0]}, 3'b000);
    end
    drain();

    send(0, 2'b00, 4'd9, 4'd8, 1'b1);
    drain();
    chk_eq("add_9_8", {last_id, last_fl, last_res}, {1'b0, 3'b000, 5'b10001});

    send(1, 2'b01, 4'd5, 4'd3, 1'b1);
    drain();
    chk_eq("sub_5_3", {last_id, last_res}, {1'b1, 5'd2});
    send(1, 2'b01, 4'd3, 4'd5, 1'b1);
    drain();
    chk_eq("sub_3_5", last_res, 5'b01110);

    send(0, 2'b10, 4'd6, 4'd6, 1'b1);
    drain();
    chk_eq("cmp_eq", {last_fl, last_res}, {3'b001, 5'd0});
    send(0, 2'b10, 4'd7, 4'd2, 1'b1);
    drain();
    chk_eq("cmp_gt", {last_fl, last_res}, {3'b010, 5'd0});
    send(1, 2'b10, 4'd1, 4'd12, 1'b1);
    drain();
    chk_eq("cmp_lt", {last_fl, last_res}, {3'b100, 5'd0});

    // Consumer stalls in RESP while the other requester keeps asking
    send(0, 2'b11, 4'd12, 4'd10, 1'b0);
    op1 = 2'b00; a1 = 4'd3; b1 = 4'd3; v1 = 1'b1;
    k = 0;
    while (!rv && k < 20) begin
      tick();
      k++;
    end
    repeat (5) tick();
    chk_eq("stall_hold", {rv, r1, rid, rres}, {1'b1, 1'b0, 1'b0, 5'd8});
    rr = 1'b1;
    drain();
    chk_eq("after_stall", {last_id, last_res}, {1'b1, 5'd6});

    // Reset while the op is in ISSUE: dropped without a response
    send(0, 2'b00, 4'd15, 4'd15, 1'b1);
    hs_before = tot_hs;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("rst_mid_op", {rv, rid, rfl, rres, s1, s0, aa, ab}, 0);
    repeat (4) tick();
    chk_eq("rst_no_resp", tot_hs, hs_before);
`ifdef ALU_STATS_EN
    chk_eq("rst_stats", {stat1, stat0}, 0);
`endif

    for (int i = 0; i < 400; i++) begin
      if (!v0) begin
        op0 = 2'($urandom_range(0, 3)); a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) v0 = 1'b1;
      end else if ($urandom_range(0, 9) == 0) v0 = 1'b0;
      if (!v1) begin
        op1 = 2'($urandom_range(0, 3)); a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) v1 = 1'b1;
      end else if ($urandom_range(0, 9) == 0) v1 = 1'b0;
      rr = 1'($urandom_range(0, 1));
      tick();
    end
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    drain();
    chk_eq("random_progress", tot_hs > hs_before + 20, 1);
`ifdef ALU_STATS_EN
    chk_eq("stats_cnt0", stat0, n_hs0);
    chk_eq("stats_cnt1", stat1, n_hs1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
